// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared stage indices and defaults for the pipeline hazard controller.
package pipe_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int DEF_NUM_STAGES = 5;

  typedef logic [DEF_NUM_STAGES-1:0] stage_vec_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus: pipeline requests in, stall/bubble/flush and perf readout out.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  rdy_i;
  logic [NUM_STAGES-1:0] stall_req_i;
  logic [NUM_STAGES-1:0] flush_req_i;
  logic [NUM_STAGES-1:0] stall_o;
  logic [NUM_STAGES-1:0] bubble_o;
  logic [NUM_STAGES-1:0] flush_o;
  logic [SEL_W-1:0]      perf_sel_i;
  logic                  perf_clr_i;
  logic [CNT_W-1:0]      perf_cnt_o;
  logic                  wdog_o;

  modport master (
    output rdy_i, stall_req_i, flush_req_i, perf_sel_i, perf_clr_i,
    input  stall_o, bubble_o, flush_o, perf_cnt_o, wdog_o
  );

  modport slave (
    input  rdy_i, stall_req_i, flush_req_i, perf_sel_i, perf_clr_i,
    output stall_o, bubble_o, flush_o, perf_cnt_o, wdog_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush controller for an N-stage in-order pipeline, with deferred
// flushes, per-stage stall counters and a stall watchdog.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int RL_W  = $clog2(WDOG_CYCLES + 1);

  logic                  w_rdy;
  logic [NUM_STAGES-1:0] w_req_or;
  logic [NUM_STAGES-1:0] w_stall;
  logic [NUM_STAGES-1:0] w_bubble;
  logic [NUM_STAGES-1:0] w_flush;
  logic [NUM_STAGES-1:0] w_eff;
  logic [NUM_STAGES-1:0] w_pend_nxt;
  logic [NUM_STAGES-1:0] r_pend;
  logic                  w_found;
  int                    w_src;
  logic [CNT_W-1:0]      w_cnt [NUM_STAGES];
  logic [CNT_W-1:0]      w_sel_cnt;
  logic [CNT_W-1:0]      r_perf;
  logic [RL_W-1:0]       w_run;
  logic                  w_wd_inc;
  logic                  w_wd_clr;
  logic                  r_wdog;

  assign w_rdy = bus.rdy_i;

  // w_req_or[k] = any request from stage max(k,1) or older; IF's own request never stalls IF.
  always_comb begin
    w_req_or = '0;
    w_req_or[NUM_STAGES-1] = bus.stall_req_i[NUM_STAGES-1];
    for (int k = NUM_STAGES - 2; k >= 1; k--) begin
      w_req_or[k] = bus.stall_req_i[k] | w_req_or[k+1];
    end
    w_req_or[0] = w_req_or[1];
  end

  assign w_stall = {NUM_STAGES{~w_rdy}} | w_req_or;

  always_comb begin
    w_eff   = bus.flush_req_i | r_pend;
    w_found = 1'b0;
    w_src   = 0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (w_eff[k]) begin
        w_found = 1'b1;
        w_src   = k;
      end
    end
  end

  // Oldest flush source wins; a stalled source parks in its pend bit and drops younger ones.
  always_comb begin
    w_flush    = '0;
    w_pend_nxt = '0;
    if (!w_rdy) begin
      w_pend_nxt = r_pend | bus.flush_req_i;
    end else if (w_found) begin
      if (!w_stall[w_src]) begin
        for (int j = 0; j < NUM_STAGES; j++) begin
          if (j < w_src) w_flush[j] = 1'b1;
        end
      end else begin
        w_pend_nxt[w_src] = 1'b1;
      end
    end
  end

  always_comb begin
    w_bubble = '0;
    if (w_rdy) begin
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
        w_bubble[k+1] = bus.stall_req_i[k] & ~w_stall[k+1];
      end
    end
    w_bubble = w_bubble & ~w_flush;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_pend <= '0;
    else          r_pend <= w_pend_nxt;
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (w_rdy & w_stall[g]),
      .clr_i   (bus.perf_clr_i),
      .cnt_o   (w_cnt[g])
    );
  end

  always_comb begin
    w_sel_cnt = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (bus.perf_sel_i == SEL_W'(k)) w_sel_cnt = w_cnt[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              r_perf <= '0;
    else if (bus.perf_clr_i)   r_perf <= '0;
    else                       r_perf <= w_sel_cnt;
  end

  assign w_wd_inc = w_rdy & w_stall[0];
  assign w_wd_clr = bus.perf_clr_i | (w_rdy & ~w_stall[0]);

  sat_counter #(.W(RL_W)) u_run (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_wd_inc),
    .clr_i   (w_wd_clr),
    .cnt_o   (w_run)
  );

  // Flag is raised on the edge that completes the WDOG_CYCLES-th counted stall cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                            r_wdog <= 1'b0;
    else if (bus.perf_clr_i)                                 r_wdog <= 1'b0;
    else if (w_wd_inc && (w_run >= RL_W'(WDOG_CYCLES - 1)))  r_wdog <= 1'b1;
  end

  assign bus.stall_o    = {NUM_STAGES{rst_n_i}} & w_stall;
  assign bus.bubble_o   = {NUM_STAGES{rst_n_i}} & w_bubble;
  assign bus.flush_o    = {NUM_STAGES{rst_n_i}} & w_flush;
  assign bus.perf_cnt_o = r_perf;
  assign bus.wdog_o     = r_wdog;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with N=5 and an 8-cycle watchdog.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int N  = 5;
  localparam int CW = 16;
  localparam int WD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_STAGES(N), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.NUM_STAGES(N), .CNT_W(CW), .WDOG_CYCLES(WD)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [4:0] st, input logic [4:0] bb,
                            input logic [4:0] fl);
    check({tag, ".stall"},  32'(bus.stall_o),  32'(st));
    check({tag, ".bubble"}, 32'(bus.bubble_o), 32'(bb));
    check({tag, ".flush"},  32'(bus.flush_o),  32'(fl));
  endtask

  initial begin
    bus.rdy_i       = 1'b1;
    bus.stall_req_i = 5'b01000;
    bus.flush_req_i = 5'b00100;
    bus.perf_sel_i  = 3'd0;
    bus.perf_clr_i  = 1'b0;
    #3;
    check_outs("reset", 5'b0, 5'b0, 5'b0);
    check("reset.wdog", 32'(bus.wdog_o), 32'd0);
    check("reset.perf", 32'(bus.perf_cnt_o), 32'd0);
    bus.stall_req_i = '0;
    bus.flush_req_i = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // MEM stall
    bus.stall_req_i = 5'b01000;
    bus.perf_sel_i  = 3'd3;
    settle();
    check_outs("mem_stall", 5'b01111, 5'b10000, 5'b00000);
    tick(); tick(); tick();
    check("perf_lag", 32'(bus.perf_cnt_o), 32'd2);
    bus.stall_req_i = '0;
    tick();
    check("perf_cnt3", 32'(bus.perf_cnt_o), 32'd3);
    bus.perf_sel_i = 3'd0;
    tick();
    check("perf_cnt0", 32'(bus.perf_cnt_o), 32'd3);
    bus.perf_sel_i = 3'd4;
    tick();
    check("perf_cnt4", 32'(bus.perf_cnt_o), 32'd0);
    bus.perf_sel_i = 3'd5;
    tick();
    check("perf_oor", 32'(bus.perf_cnt_o), 32'd0);

    // IF-only and ID+IF requests
    bus.stall_req_i = 5'b00001;
    settle();
    check_outs("if_only", 5'b00000, 5'b00010, 5'b00000);
    bus.stall_req_i = 5'b00011;
    settle();
    check_outs("id_if", 5'b00011, 5'b00100, 5'b00000);
    bus.stall_req_i = '0;

    // Immediate flush from EX
    bus.flush_req_i = 5'b00100;
    settle();
    check_outs("flush_ex", 5'b00000, 5'b00000, 5'b00011);
    tick();
    bus.flush_req_i = '0;
    settle();
    check("flush_ex_after", 32'(bus.flush_o), 32'd0);

    // Flush masks bubble
    bus.stall_req_i = 5'b00001;
    bus.flush_req_i = 5'b00100;
    settle();
    check_outs("flush_over_bubble", 5'b00000, 5'b00000, 5'b00011);
    bus.stall_req_i = '0;
    bus.flush_req_i = '0;
    tick();

    // Flush deferred behind a MEM stall
    bus.stall_req_i = 5'b01000;
    bus.flush_req_i = 5'b00100;
    settle();
    check("pend_c0", 32'(bus.flush_o), 32'd0);
    tick();
    bus.flush_req_i = '0;
    settle();
    check("pend_c1", 32'(bus.flush_o), 32'd0);
    tick();
    settle();
    check("pend_c2", 32'(bus.flush_o), 32'd0);
    tick();
    bus.stall_req_i = '0;
    settle();
    check_outs("pend_apply", 5'b00000, 5'b00000, 5'b00011);
    tick();
    settle();
    check("pend_cleared", 32'(bus.flush_o), 32'd0);

    // Simultaneous flushes: older wins, younger dropped
    bus.flush_req_i = 5'b00110;
    settle();
    check("simul_flush", 32'(bus.flush_o), 32'h03);
    tick();
    bus.flush_req_i = '0;
    settle();
    check("simul_nopend", 32'(bus.flush_o), 32'd0);

    // rdy low freezes everything and parks live flushes
    bus.rdy_i       = 1'b0;
    bus.stall_req_i = 5'b00001;
    bus.flush_req_i = 5'b00100;
    settle();
    check_outs("rdy_low", 5'b11111, 5'b00000, 5'b00000);
    tick();
    bus.rdy_i       = 1'b1;
    bus.stall_req_i = '0;
    bus.flush_req_i = '0;
    settle();
    check("rdy_pend_apply", 32'(bus.flush_o), 32'h03);
    tick();

    // Watchdog: 8 counted stall cycles with a 2-cycle rdy gap
    bus.stall_req_i = 5'b00010;
    repeat (4) tick();
    bus.rdy_i = 1'b0;
    repeat (2) tick();
    bus.rdy_i = 1'b1;
    repeat (3) tick();
    check("wdog_7", 32'(bus.wdog_o), 32'd0);
    tick();
    check("wdog_8", 32'(bus.wdog_o), 32'd1);
    tick();
    check("wdog_9", 32'(bus.wdog_o), 32'd1);
    bus.stall_req_i = '0;
    bus.perf_sel_i  = 3'd1;
    tick();
    check("wdog_sticky", 32'(bus.wdog_o), 32'd1);
    check("perf_cnt1", 32'(bus.perf_cnt_o), 32'd15);
    bus.perf_clr_i = 1'b1;
    tick();
    bus.perf_clr_i = 1'b0;
    settle();
    check("clr_wdog", 32'(bus.wdog_o), 32'd0);
    check("clr_perf", 32'(bus.perf_cnt_o), 32'd0);
    tick();
    check("clr_cnt1", 32'(bus.perf_cnt_o), 32'd0);

    // Async reset with a pending flush
    bus.stall_req_i = 5'b01000;
    bus.flush_req_i = 5'b00100;
    tick();
    bus.flush_req_i = '0;
    settle();
    check("rst_pre_flush", 32'(bus.flush_o), 32'd0);
    rst_n = 1'b0;
    settle();
    check_outs("rst_mid", 5'b0, 5'b0, 5'b0);
    check("rst_mid.wdog", 32'(bus.wdog_o), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.stall_req_i = '0;
    settle();
    check_outs("rst_release", 5'b0, 5'b0, 5'b0);
    tick();
    check("rst_no_stale", 32'(bus.flush_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
